// File: rtl/demorgan_pkg.sv
`default_nettype none
// ==== demorgan_pkg : sweep FSM states and shared sweep helpers | rev 1.0 ====
package demorgan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int SETTLE_MIN = 1;
    localparam int N_MAX      = 8;

    function automatic logic [N_MAX-1:0] last_vec(input int n);
        return N_MAX'((1 << n) - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ==== settle_timer : loadable up-counter, flags count == SETTLE-1 | rev 1.0 ====
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    import demorgan_pkg::*;

    localparam int S_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
    localparam int CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc_o = (count_q == CW'(S_EFF - 1));

endmodule
`default_nettype wire

// File: rtl/demorgan_exhaustive_checker.sv
`default_nettype none
// ==== demorgan_exhaustive_checker : sweeps all N-bit vectors, compares lhs/rhs | rev 1.0 ====
module demorgan_exhaustive_checker #(
    parameter int N      = 2,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    output logic [N-1:0] vec_o,
    input  logic         lhs_i,
    input  logic         rhs_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic [N:0]   mismatch_cnt_o,
    output logic         fail_valid_o,
    output logic [N-1:0] first_fail_o
);
    import demorgan_pkg::*;

    localparam logic [N-1:0] LAST_VEC = N'(last_vec(N));

    state_t       state_q;
    logic [N-1:0] vec_q;
    logic         busy_q;
    logic         done_q;
    logic         pass_q;
    logic [N:0]   cnt_q;
    logic         fail_valid_q;
    logic [N-1:0] first_fail_q;

    logic         tc;
    logic         timer_load;
    logic         timer_en;
    logic         differ;
    logic [N:0]   cnt_inc;

    assign differ     = lhs_i ^ rhs_i;
    assign cnt_inc    = cnt_q + (N+1)'(1);
    assign timer_load = ((state_q == S_IDLE) && start_i) || (state_q == S_CHECK);
    assign timer_en   = (state_q == S_APPLY);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .en_i   (timer_en),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            cnt_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_APPLY;
                        vec_q        <= '0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        cnt_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                    end
                end
                S_APPLY: begin
                    if (tc) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (differ) begin
                        cnt_q <= cnt_inc;
                        if (!fail_valid_q) begin
                            first_fail_q <= vec_q;
                            fail_valid_q <= 1'b1;
                        end
                    end
                    // Verdict is registered on entry to DONE so it is already stable in the done cycle.
                    if (vec_q == LAST_VEC) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (cnt_q == '0) && !differ;
                    end else begin
                        vec_q   <= vec_q + N'(1);
                        state_q <= S_APPLY;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vec_o          = vec_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign mismatch_cnt_o = cnt_q;
    assign fail_valid_o   = fail_valid_q;
    assign first_fail_o   = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_demorgan_exhaustive_checker.sv
`default_nettype none
// ==== tb_demorgan_exhaustive_checker : scoreboard bench, N=2/S=1 and N=3/S=3 | rev 1.0 ====
module tb_demorgan_exhaustive_checker;

    typedef struct {
        int cnt;
        bit fv;
        int first;
        bit pass;
    } exp_t;

    localparam int LA = 8;   // 2^2 * (1+1)
    localparam int PA = 2;
    localparam int LB = 32;  // 2^3 * (3+1)
    localparam int PB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    int         mode;
    logic [7:0] mask;

    logic [1:0] vec_a, ff_a;
    logic [2:0] cnt_a;
    logic       lhs_a, rhs_a, busy_a, done_a, pass_a, fv_a;
    logic [2:0] vec_b, ff_b;
    logic [3:0] cnt_b;
    logic       lhs_b, rhs_b, busy_b, done_b, pass_b, fv_b;

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    bit   run_a = 1'b0, run_b = 1'b0;
    int   k_a = 0, k_b = 0;

    always #5 clk = ~clk;

    demorgan_exhaustive_checker #(.N(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(start), .vec_o(vec_a), .lhs_i(lhs_a), .rhs_i(rhs_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .mismatch_cnt_o(cnt_a),
        .fail_valid_o(fv_a), .first_fail_o(ff_a)
    );

    demorgan_exhaustive_checker #(.N(3), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst(rst), .start_i(start), .vec_o(vec_b), .lhs_i(lhs_b), .rhs_i(rhs_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .mismatch_cnt_o(cnt_b),
        .fail_valid_o(fv_b), .first_fail_o(ff_b)
    );

    // Gate pairs under study: NOR form on lhs, selectable second form on rhs.
    function automatic bit lhs_fn(logic [7:0] v, int n);
        bit any = 1'b0;
        for (int i = 0; i < 8; i++) if (i < n) any |= v[i];
        return !any;
    endfunction

    function automatic bit rhs_fn(int m, logic [7:0] v, int n, logic [7:0] mk);
        bit ai = 1'b1;
        bit al = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                ai &= !v[i];
                al &= v[i];
            end
        end
        case (m)
            0:       return ai;
            1:       return !al;
            2:       return !lhs_fn(v, n);
            default: return ai ^ mk[v[2:0]];
        endcase
    endfunction

    function automatic exp_t model(int n, int m, logic [7:0] mk);
        exp_t e;
        e.cnt = 0; e.fv = 1'b0; e.first = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (lhs_fn(8'(v), n) != rhs_fn(m, 8'(v), n, mk)) begin
                if (!e.fv) begin
                    e.fv = 1'b1;
                    e.first = v;
                end
                e.cnt++;
            end
        end
        e.pass = (e.cnt == 0);
        return e;
    endfunction

    always_comb begin
        lhs_a = lhs_fn({6'b0, vec_a}, 2);
        rhs_a = rhs_fn(mode, {6'b0, vec_a}, 2, mask);
        lhs_b = lhs_fn({5'b0, vec_b}, 3);
        rhs_b = rhs_fn(mode, {5'b0, vec_b}, 3, mask);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor A: tracks cycle index since accepted start, pops verdict on done.
    always @(negedge clk) begin
        if (rst) begin
            run_a = 1'b0;
            q_a.delete();
        end else if (run_a) begin
            k_a++;
            if (k_a <= LA) begin
                check("a_busy", 32'(busy_a), 1);
                check("a_done_early", 32'(done_a), 0);
                check("a_vec", 32'(vec_a), 32'((k_a - 1) / PA));
            end else begin
                exp_t e;
                check("a_done_cycle", 32'(done_a), 1);
                check("a_busy_done", 32'(busy_a), 0);
                if (q_a.size() == 0) begin
                    check("a_scoreboard_empty", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_mismatch_cnt", 32'(cnt_a), 32'(e.cnt));
                    check("a_fail_valid", 32'(fv_a), 32'(e.fv));
                    check("a_pass", 32'(pass_a), 32'(e.pass));
                    if (e.fv) check("a_first_fail", 32'(ff_a), 32'(e.first));
                end
                run_a = 1'b0;
            end
        end else begin
            if (done_a) check("a_stray_done", 32'(done_a), 0);
            if (start && !busy_a && !done_a) begin
                run_a = 1'b1;
                k_a = 0;
            end
        end
    end

    // Monitor B: same timeline rules for N=3, SETTLE=3.
    always @(negedge clk) begin
        if (rst) begin
            run_b = 1'b0;
            q_b.delete();
        end else if (run_b) begin
            k_b++;
            if (k_b <= LB) begin
                check("b_busy", 32'(busy_b), 1);
                check("b_done_early", 32'(done_b), 0);
                check("b_vec", 32'(vec_b), 32'((k_b - 1) / PB));
            end else begin
                exp_t e;
                check("b_done_cycle", 32'(done_b), 1);
                check("b_busy_done", 32'(busy_b), 0);
                if (q_b.size() == 0) begin
                    check("b_scoreboard_empty", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("b_mismatch_cnt", 32'(cnt_b), 32'(e.cnt));
                    check("b_fail_valid", 32'(fv_b), 32'(e.fv));
                    check("b_pass", 32'(pass_b), 32'(e.pass));
                    if (e.fv) check("b_first_fail", 32'(ff_b), 32'(e.first));
                end
                run_b = 1'b0;
            end
        end else begin
            if (done_b) check("b_stray_done", 32'(done_b), 0);
            if (start && !busy_b && !done_b) begin
                run_b = 1'b1;
                k_b = 0;
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_vec_a"}, 32'(vec_a), 0);
        check({tag, "_busy_a"}, 32'(busy_a), 0);
        check({tag, "_cnt_a"}, 32'(cnt_a), 0);
        check({tag, "_fv_a"}, 32'(fv_a), 0);
        check({tag, "_vec_b"}, 32'(vec_b), 0);
        check({tag, "_busy_b"}, 32'(busy_b), 0);
        check({tag, "_cnt_b"}, 32'(cnt_b), 0);
        check({tag, "_fv_b"}, 32'(fv_b), 0);
    endtask

    task automatic sweep(input int m, input logic [7:0] mk, input bit busy_pulse, input bit do_rst);
        exp_t ea;
        mode = m;
        mask = mk;
        ea = model(2, m, mk);
        q_a.push_back(ea);
        q_b.push_back(model(3, m, mk));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (busy_pulse) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        if (do_rst) begin
            repeat (4) @(posedge clk);
            #1 rst = 1'b1;
            #1 check_cleared("midrst");
            check("midrst_done_a", 32'(done_a), 0);
            @(posedge clk); #1 rst = 1'b0;
        end else begin
            for (int i = 0; i < 100; i++) begin
                if (!run_a && !run_b) break;
                @(posedge clk);
            end
            if (run_a || run_b) check("sweep_timeout", 1, 0);
            #1;
            check("idle_vec_a_held", 32'(vec_a), 3);
            check("idle_vec_b_held", 32'(vec_b), 7);
            check("idle_pass_a_held", 32'(pass_a), 32'(ea.pass));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 0;
        mask  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        check("reset_done_a", 32'(done_a), 0);
        check("reset_pass_a", 32'(pass_a), 0);
        check("reset_ff_b", 32'(ff_b), 0);
        rst = 1'b0;

        sweep(0, 8'h00, 1'b0, 1'b0);   // equivalent pairs
        sweep(1, 8'h00, 1'b0, 1'b0);   // NAND instead of AND-of-inverts
        sweep(2, 8'h00, 1'b0, 1'b0);   // every vector mismatches
        sweep(0, 8'h00, 1'b1, 1'b0);   // extra start while busy
        sweep(1, 8'h00, 1'b0, 1'b1);   // reset mid-sweep
        sweep(0, 8'h00, 1'b0, 1'b0);   // recovery after reset
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            sweep(3, 8'($urandom), 1'b0, 1'b0);
        end

        check("final_q_a_empty", 32'(q_a.size()), 0);
        check("final_q_b_empty", 32'(q_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demorgan_exhaustive_checker.md
# demorgan_exhaustive_checker

Sequencer that exhaustively exercises a pair of externally instantiated N-input gate implementations, such as the NOR form ~(x0|x1|…) against the AND-of-inverts form (~x0&~x1&…). It drives every input vector in ascending order, waits a programmable settle time, and compares the two outputs. It reports a pass/fail verdict, a mismatch count and the first failing vector. It sits in the lab top level between the switch/button front end and the De Morgan gate pairs under study.

## Interface
Parameters:
- N, default 2: input vector width; the sweep covers 2^N vectors; legal range 1..8.
- SETTLE, default 1: cycles each vector is held before sampling; SETTLE ≥ 1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level, sampled in IDLE only; begins a sweep.
- vec  output  N  vector driven to both gate implementations; reset 0.
- lhs  input  1  output of implementation A (e.g. NOR form).
- rhs  input  1  output of implementation B (e.g. AND-of-inverts form).
- busy  output  1  high from the first APPLY cycle through the last CHECK cycle; reset 0.
- done  output  1  one-cycle pulse at sweep end; reset 0.
- pass  output  1  valid after done; 1 iff mismatch_cnt == 0; held until the next start; reset 0.
- mismatch_cnt  output  N+1  number of vectors with lhs≠rhs; reset 0.
- fail_valid  output  1  at least one mismatch seen this sweep; reset 0.
- first_fail  output  N  vec value of the first mismatch; meaningful only when fail_valid=1; reset 0.

## Operation
- States: IDLE, APPLY, CHECK, DONE.
- IDLE, start=1: go to APPLY.
  - Clear vec, mismatch_cnt, fail_valid, first_fail and pass.
  - Load settle counter with 0.
- APPLY: hold vec and increment the settle counter.
  - When the counter == SETTLE-1, go to CHECK.
- CHECK: sample lhs and rhs.
  - If they differ, increment mismatch_cnt.
  - If they differ and fail_valid=0, capture first_fail=vec and set fail_valid.
  - If vec == all-ones, go to DONE and hold vec.
  - Otherwise set vec=vec+1, reset the settle counter and go to APPLY.
- DONE: assert done for 1 cycle; pass <= (mismatch_cnt==0), counting the final CHECK result; go to IDLE.
- Result retention:
  - mismatch_cnt, fail_valid, first_fail and pass hold in IDLE until the next accepted start.
  - vec holds its last value (all-ones) in IDLE.
- Width rules:
  - mismatch_cnt is N+1 bits so the count 2^N is representable without wrap.
  - The vec increment never wraps inside a sweep because the all-ones test precedes it.
- Start handling: start is ignored in APPLY, CHECK and DONE; no restart or queueing. A start held high through DONE starts a new sweep on the first IDLE cycle.
- Reset mid-sweep: asynchronous return to IDLE with all outputs at reset values; partial results are discarded.
- lhs and rhs are only sampled in CHECK. The caller guarantees combinational settle within SETTLE cycles.

## Timing
- Cycle 0: IDLE with start=1.
- Cycles 1..SETTLE: APPLY with vec=0.
- Cycle SETTLE+1: CHECK of vector 0.
- Each vector costs SETTLE+1 cycles.
- Last CHECK at cycle 2^N·(SETTLE+1). done is high in cycle 2^N·(SETTLE+1)+1.
- Example N=2, SETTLE=1: CHECK at cycles 2, 4, 6, 8; done in cycle 9; back in IDLE at cycle 10.
- pass, mismatch_cnt and first_fail are stable in the done cycle and thereafter.
- All outputs are registered; no combinational path from lhs, rhs or start to any output.

## Structure
- Shared package demorgan_pkg holds:
  - the state enum (IDLE, APPLY, CHECK, DONE);
  - a localparam for the SETTLE minimum;
  - a function giving the last vector (all-ones of width N), reused by sibling sweep blocks.
- One natural sub-module: settle_timer. It is a loadable counter with a terminal-count flag, parameterized by SETTLE.
- The gate pairs under test stay outside this block and connect through vec, lhs and rhs.

## Test plan
- Equivalent pair: N=2, SETTLE=1, lhs=~(a|b), rhs=~a&~b, start pulse.
  - Required: done in cycle 9, pass=1, mismatch_cnt=0, fail_valid=0.
- Broken pair: rhs=~(a&b).
  - Required: mismatches at vec=01 and 10; mismatch_cnt=2, fail_valid=1, first_fail=2'b01, pass=0.
- Start while busy: pulse start again at cycle 4 of a sweep.
  - Required: sweep unaffected; done still in cycle 9; exactly one done pulse.
- Reset mid-sweep: assert rst at cycle 5.
  - Required: immediately vec=0, busy=0, mismatch_cnt=0, fail_valid=0.
  - A new start after release completes normally.
- SETTLE=3, N=3, equivalent 3-input pair.
  - Required: vec holds 3 cycles before each CHECK; done in cycle 33; pass=1.
- All-mismatch: rhs=~lhs.
  - Required: mismatch_cnt=2^N (4 for N=2, no wrap), first_fail=0.
